msk_kat_checker: RTL and testbench
==================================

# msk_kat_checker

Synthesizable known-answer-test harness placed in front of a masked AES core (`MSKaes_32bits_core` interface), for on-chip regression and FPGA bring-up. It accepts unmasked vectors (plaintext, key, expected result, mode), splits them into `d` shares with an internal LFSR, and converts them to shbus encoding. It drives the core through its valid/ready handshakes with randomised input gaps and output back-pressure, recombines the ciphertext shares, checks them against an expected-value FIFO, and keeps pass/fail statistics.

## Interface
- `d`, 2, number of shares (≥2).
- `DEPTH`, 4, expected-value FIFO depth (power of two, ≥2).
- `MASK_EN`, 1, 1: shares 1..d-1 come from the LFSR; 0: those shares are zero.
- `LFSR_SEED`, 32'hACE1_2024, reset value of the LFSR; must be nonzero.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `vec_valid`  in  1  vector offered.
- `vec_ready`  out  1  vector accepted this cycle when high together with `vec_valid`.
- `vec_plaintext`  in  128  unmasked input block.
- `vec_key`  in  256  unmasked key; bits [255:128] are ignored when `vec_mode256`=0.
- `vec_expected`  in  128  expected unmasked output.
- `vec_inverse`  in  1  decryption.
- `vec_mode256`  in  1  AES-256.
- `gap_mask`  in  8  random idle gap before `core_valid_in`; gap = `lfsr[7:0] & gap_mask`; 0 gives continuous operation.
- `bp_en`  in  1  enables random output back-pressure.
- `core_valid_in`  out  1  to core `valid_in`.
- `core_in_ready`  in  1  from core `in_ready`.
- `core_inverse`  out  1  to core `inverse`.
- `core_mode_256`  out  1  to core `mode_256`.
- `core_sh_plaintext`  out  128·d  shbus-encoded plaintext.
- `core_sh_key`  out  256·d  shbus-encoded key.
- `core_cipher_valid`  in  1  from core `cipher_valid`.
- `core_out_ready`  out  1  to core `out_ready`.
- `core_sh_ciphertext`  in  128·d  shbus-encoded result.
- `n_done`  out  32  results checked (saturating).
- `n_fail`  out  32  mismatches, including unexpected results (saturating).
- `first_fail_idx`  out  32  value of `n_done` at the first failure.
- `fail_seen`  out  1  sticky failure flag.
- `mismatch_pulse`  out  1  one-cycle pulse for each failure.

## Operation
- Shbus encoding: bit i of share j is at index i·d+j. Share 0 = value XOR shares 1..d-1.
- Share j≥1 mask word: m_j = rotl(lfsr, 5·j). The plaintext mask is m_j replicated 4×; the key mask is m_j replicated 8×. This masking is test-quality only.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, advances every cycle.
- Input FSM:
  - IDLE: `vec_ready` = !fifo_full && compat, where compat = fifo_empty OR (`vec_inverse`,`vec_mode256`) equals the latched mode.
  - On accept: register the shares and mode, push `vec_expected` into the FIFO, load gap. Go to GAP if gap≠0, otherwise go to DRIVE.
  - GAP: count down to 1, then go to DRIVE.
  - DRIVE: assert `core_valid_in`. Go to IDLE on `core_in_ready`.
- Output: `core_out_ready` = !`bp_en` | r_bp, where r_bp is a registered LFSR bit 31.
- On fire (`core_cipher_valid`&`core_out_ready`): recombine the shares and pop the FIFO.
  - Compare against the popped value; on mismatch, fail.
  - If the FIFO is empty at fire, this is an unexpected result: fail, and no pop.
- Failure handling: increment `n_fail`, pulse `mismatch_pulse`, set `fail_seen`. On the first failure, also capture `first_fail_idx`.
- Every fire increments `n_done`.

## Timing
- Reset (async, immediate): FSM in IDLE, FIFO empty, LFSR=`LFSR_SEED`, all outputs 0 except `core_out_ready` = !`bp_en`. A reset mid-operation drops `core_valid_in` immediately.
- Core inputs are registered and stay stable from the accept cycle+1 until the `core_in_ready` handshake completes.
- Latency from accept to `core_valid_in` high: 1+gap cycles.
- `vec_ready` is combinational from state, FIFO flags and mode compare. It is low in GAP and DRIVE, so at most one vector is in flight towards the core.
- FIFO full: `vec_ready` is low, and a pop frees the slot for the next cycle. A push and a pop in the same cycle are both honoured.
- A mode change waits for FIFO empty.
- Status outputs and `mismatch_pulse` are registered and update 1 cycle after fire.
- Counters saturate at 2^32-1.

## Structure
- `msk_kat_pkg`: LFSR polynomial and seed constant, the shbus index function, the mask rotate step (5), and the FSM state enum (IDLE, GAP, DRIVE).
- Sub-module `msk_kat_exp_fifo`: synchronous 128-bit FIFO with `DEPTH` entries, wrap-around pointers and an extra pointer bit for full/empty detection.

## Test plan
- FIPS-197 AES-128, `gap_mask`=0, `bp_en`=0: pt 00112233445566778899aabbccddeeff, key 000102…0f, exp 69c4e0d86a7b0430d8cdb78070b4c55a -> `n_done`=1, `n_fail`=0.
- AES-256: key 000102…1f, same pt, exp 8ea2b7ca516745bfeafc49904b496089; then AES-128 decryption of 69c4…c55a -> 00112233…ff. The mode switch stalls `vec_ready` until the FIFO is empty; no failures.
- Wrong expected value (last byte 5b) -> `mismatch_pulse` for one cycle, `n_fail`=1, `fail_seen`=1, `first_fail_idx`=0.
- 1000 vectors with `gap_mask`=8'h3F, `bp_en`=1, d=3 -> `n_fail`=0, and the core inputs are never changed while `core_valid_in` is high and `core_in_ready` is low.
- Model core stalls output while vectors keep arriving -> FIFO fills, `vec_ready` stays low at DEPTH outstanding vectors, and resumes the cycle after a pop.
- `rst` asserted in DRIVE -> `core_valid_in` goes to 0 asynchronously and counters clear; `core_cipher_valid` afterwards -> counted as an unexpected result (`n_fail`=1).

Source files
------------

// File: rtl/msk_kat_pkg.sv
// Shared constants, helpers and state encoding for the masked-AES KAT checker.
package msk_kat_pkg;

  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1 (term x^k -> bit k-1)
  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEF = 32'hACE1_2024;
  // Share j uses the LFSR word rotated left by MASK_ROT*j
  localparam int          MASK_ROT      = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_DRIVE
  } state_t;

  // shbus position of bit i of share j with nsh shares
  function automatic int shidx(input int i, input int j, input int nsh);
    return i * nsh + j;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} << (n % 32);
    return t[63:32];
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/msk_kat_exp_fifo.sv
// Expected-value FIFO; pointers carry an extra wrap bit to tell full from empty.
module msk_kat_exp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;

  // Pointer update; push and pop in the same cycle both take effect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/msk_kat_checker.sv
// KAT harness in front of a masked AES core: masks vectors into shbus shares,
// drives the core handshakes with random gaps/back-pressure, checks results.
module msk_kat_checker
  import msk_kat_pkg::*;
#(
  parameter int          d         = 2,
  parameter int          DEPTH     = 4,
  parameter int          MASK_EN   = 1,
  parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [127:0]         vec_plaintext,
  input  logic [255:0]         vec_key,
  input  logic [127:0]         vec_expected,
  input  logic                 vec_inverse,
  input  logic                 vec_mode256,
  input  logic [7:0]           gap_mask,
  input  logic                 bp_en,
  output logic                 core_valid_in,
  input  logic                 core_in_ready,
  output logic                 core_inverse,
  output logic                 core_mode_256,
  output logic [128*d-1:0]     core_sh_plaintext,
  output logic [256*d-1:0]     core_sh_key,
  input  logic                 core_cipher_valid,
  output logic                 core_out_ready,
  input  logic [128*d-1:0]     core_sh_ciphertext,
  output logic [31:0]          n_done,
  output logic [31:0]          n_fail,
  output logic [31:0]          first_fail_idx,
  output logic                 fail_seen,
  output logic                 mismatch_pulse
);

  logic [31:0]        r_lfsr;
  logic               r_bp;
  state_t             r_state;
  logic [7:0]         r_gap;
  logic               r_valid;
  logic               r_inv;
  logic               r_m256;
  logic [128*d-1:0]   r_pt_sh;
  logic [256*d-1:0]   r_key_sh;
  logic [31:0]        r_done;
  logic [31:0]        r_fail;
  logic [31:0]        r_first;
  logic               r_seen;
  logic               r_pulse;

  logic [31:0]        w_m [d];
  logic [31:0]        w_mx;
  logic [255:0]       w_key_eff;
  logic [128*d-1:0]   w_pt_enc;
  logic [256*d-1:0]   w_key_enc;
  logic [127:0]       w_ct;
  logic [127:0]       w_exp;
  logic [7:0]         w_gap;
  logic               w_empty;
  logic               w_full;
  logic               w_compat;
  logic               w_accept;
  logic               w_fire;
  logic               w_pop;

  assign w_compat  = w_empty || ({vec_inverse, vec_mode256} == {r_inv, r_m256});
  assign vec_ready = !rst && (r_state == ST_IDLE) && !w_full && w_compat;
  assign w_accept  = vec_valid && vec_ready;
  assign w_gap     = r_lfsr[7:0] & gap_mask;
  assign w_fire    = core_cipher_valid && core_out_ready;
  assign w_pop     = w_fire && !w_empty;
  assign w_key_eff = vec_mode256 ? vec_key : {128'h0, vec_key[127:0]};

  assign core_valid_in     = r_valid;
  assign core_inverse      = r_inv;
  assign core_mode_256     = r_m256;
  assign core_sh_plaintext = r_pt_sh;
  assign core_sh_key       = r_key_sh;
  assign core_out_ready    = !bp_en | r_bp;
  assign n_done            = r_done;
  assign n_fail            = r_fail;
  assign first_fail_idx    = r_first;
  assign fail_seen         = r_seen;
  assign mismatch_pulse    = r_pulse;

  // Per-share mask words; share 0 absorbs the XOR of all of them
  always_comb begin
    w_mx = '0;
    for (int j = 0; j < d; j++) begin
      w_m[j] = (j == 0 || MASK_EN == 0) ? 32'h0 : rotl32(r_lfsr, MASK_ROT * j);
      w_mx   = w_mx ^ w_m[j];
    end
  end

  for (genvar j = 0; j < d; j++) begin : g_sh
    logic [127:0] w_pt_j;
    logic [255:0] w_key_j;
    assign w_pt_j  = (j == 0) ? (vec_plaintext ^ {4{w_mx}}) : {4{w_m[j]}};
    assign w_key_j = (j == 0) ? (w_key_eff ^ {8{w_mx}}) : {8{w_m[j]}};
    for (genvar i = 0; i < 128; i++) begin : g_pt
      assign w_pt_enc[shidx(i, j, d)] = w_pt_j[i];
    end
    for (genvar i = 0; i < 256; i++) begin : g_key
      assign w_key_enc[shidx(i, j, d)] = w_key_j[i];
    end
  end

  // All d shares of a bit sit next to each other, so recombining is a reduction
  for (genvar i = 0; i < 128; i++) begin : g_rc
    assign w_ct[i] = ^core_sh_ciphertext[shidx(i, 0, d) +: d];
  end

  msk_kat_exp_fifo #(
    .DEPTH (DEPTH),
    .W     (128)
  ) u_exp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_wdata (vec_expected),
    .i_pop   (w_pop),
    .o_rdata (w_exp),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Free-running LFSR and the back-pressure bit sampled from it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
      r_bp   <= 1'b0;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
      r_bp   <= r_lfsr[31];
    end
  end

  // Input FSM: latch shares on accept, wait the random gap, hold valid until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_gap    <= '0;
      r_valid  <= 1'b0;
      r_inv    <= 1'b0;
      r_m256   <= 1'b0;
      r_pt_sh  <= '0;
      r_key_sh <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pt_sh  <= w_pt_enc;
            r_key_sh <= w_key_enc;
            r_inv    <= vec_inverse;
            r_m256   <= vec_mode256;
            r_gap    <= w_gap;
            if (w_gap != 8'd0) begin
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_DRIVE;
              r_valid <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (r_gap == 8'd1) begin
            r_state <= ST_DRIVE;
            r_valid <= 1'b1;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        ST_DRIVE: begin
          if (core_in_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Result check and saturating statistics; a result with no expectation is a failure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done  <= '0;
      r_fail  <= '0;
      r_first <= '0;
      r_seen  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_fire) begin
        if (r_done != 32'hFFFF_FFFF) r_done <= r_done + 32'd1;
        if (w_empty || (w_ct != w_exp)) begin
          if (r_fail != 32'hFFFF_FFFF) r_fail <= r_fail + 32'd1;
          r_pulse <= 1'b1;
          r_seen  <= 1'b1;
          if (!r_seen) r_first <= r_done;
        end
      end
    end
  end

endmodule

// File: tb/tb_msk_kat_checker.sv
// Bench for msk_kat_checker with a behavioural masked-core model and scoreboards.
module tb_msk_kat_checker;

  localparam int D     = 3;
  localparam int DEPTH = 4;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128    = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [255:0] K256    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C256    = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               vec_valid = 1'b0;
  logic               vec_ready;
  logic [127:0]       vec_plaintext = '0;
  logic [255:0]       vec_key = '0;
  logic [127:0]       vec_expected = '0;
  logic               vec_inverse = 1'b0;
  logic               vec_mode256 = 1'b0;
  logic [7:0]         gap_mask = 8'h00;
  logic               bp_en = 1'b1;
  logic               core_valid_in;
  logic               core_in_ready = 1'b1;
  logic               core_inverse;
  logic               core_mode_256;
  logic [128*D-1:0]   core_sh_plaintext;
  logic [256*D-1:0]   core_sh_key;
  logic               core_cipher_valid = 1'b0;
  logic               core_out_ready;
  logic [128*D-1:0]   core_sh_ciphertext = '0;
  logic [31:0]        n_done;
  logic [31:0]        n_fail;
  logic [31:0]        first_fail_idx;
  logic               fail_seen;
  logic               mismatch_pulse;

  always #5 clk = ~clk;

  msk_kat_checker #(
    .d       (D),
    .DEPTH   (DEPTH),
    .MASK_EN (1)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .vec_valid          (vec_valid),
    .vec_ready          (vec_ready),
    .vec_plaintext      (vec_plaintext),
    .vec_key            (vec_key),
    .vec_expected       (vec_expected),
    .vec_inverse        (vec_inverse),
    .vec_mode256        (vec_mode256),
    .gap_mask           (gap_mask),
    .bp_en              (bp_en),
    .core_valid_in      (core_valid_in),
    .core_in_ready      (core_in_ready),
    .core_inverse       (core_inverse),
    .core_mode_256      (core_mode_256),
    .core_sh_plaintext  (core_sh_plaintext),
    .core_sh_key        (core_sh_key),
    .core_cipher_valid  (core_cipher_valid),
    .core_out_ready     (core_out_ready),
    .core_sh_ciphertext (core_sh_ciphertext),
    .n_done             (n_done),
    .n_fail             (n_fail),
    .first_fail_idx     (first_fail_idx),
    .fail_seen          (fail_seen),
    .mismatch_pulse     (mismatch_pulse)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural core: FIPS-197 known answers, otherwise a keyed XOR stand-in
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [255:0] key,
                                           input logic inv, input logic m256);
    if (!inv && !m256 && pt == FIPS_PT && key[127:0] == K128[127:0]) return C128;
    if (!inv && m256 && pt == FIPS_PT && key == K256) return C256;
    if (inv && !m256 && pt == C128 && key[127:0] == K128[127:0]) return FIPS_PT;
    return pt ^ key[127:0] ^ (m256 ? key[255:128] : 128'h0) ^ (inv ? {4{32'hA5A5_5A5A}} : 128'h0);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [128*D-1:0] enc128(input logic [127:0] v);
    logic [127:0]     s [D];
    logic [128*D-1:0] e;
    s[0] = v;
    for (int j = 1; j < D; j++) begin
      s[j] = rand128();
      s[0] = s[0] ^ s[j];
    end
    for (int j = 0; j < D; j++)
      for (int i = 0; i < 128; i++) e[i*D+j] = s[j][i];
    return e;
  endfunction

  function automatic logic [127:0] dec128(input logic [128*D-1:0] e);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < D; j++)
      for (int i = 0; i < 128; i++) r[i] = r[i] ^ e[i*D+j];
    return r;
  endfunction

  function automatic logic [255:0] dec256(input logic [256*D-1:0] e);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < D; j++)
      for (int i = 0; i < 256; i++) r[i] = r[i] ^ e[i*D+j];
    return r;
  endfunction

  typedef struct {
    logic [127:0] pt;
    logic [255:0] key;
    logic         inv;
    logic         m256;
  } ivec_t;

  typedef struct {
    logic [128*D-1:0] enc;
    int               rdy;
  } oitem_t;

  ivec_t  in_q[$];
  bit     exp_q[$];
  oitem_t core_q[$];

  int cyc        = 0;
  int n_acc      = 0;
  int n_ofire    = 0;
  int inj_req    = 0;
  int inj_done   = 0;
  int n_unstable = 0;
  bit pend_exp   = 1'b0;
  int rdy_mode   = 0;    // 0: always ready, 1: random, 2: never
  bit out_stall  = 1'b0;

  // Handshake monitor and core-model state, sampled on the active edge
  always @(posedge clk) begin : p_mon
    ivec_t        it;
    oitem_t       oi;
    logic [127:0] rc_pt;
    logic [255:0] rc_key;
    bit           hold;
    logic [128*D-1:0] h_pt;
    logic [256*D-1:0] h_key;
    logic [1:0]   h_mode;
    cyc++;
    if (rst) begin
      in_q.delete();
      exp_q.delete();
      core_q.delete();
      inj_done = inj_req;
      hold     = 1'b0;
    end else begin
      if (hold) begin
        if (!core_valid_in || core_sh_plaintext != h_pt || core_sh_key != h_key ||
            {core_inverse, core_mode_256} != h_mode)
          n_unstable++;
      end
      hold   = core_valid_in && !core_in_ready;
      h_pt   = core_sh_plaintext;
      h_key  = core_sh_key;
      h_mode = {core_inverse, core_mode_256};

      if (vec_valid && vec_ready) begin
        it.pt   = vec_plaintext;
        it.key  = vec_key;
        it.inv  = vec_inverse;
        it.m256 = vec_mode256;
        in_q.push_back(it);
        exp_q.push_back(vec_expected != core_fn(vec_plaintext, vec_key, vec_inverse, vec_mode256));
        n_acc++;
      end

      if (core_cipher_valid && core_out_ready) begin
        if (core_q.size() > 0) void'(core_q.pop_front());
        else inj_done++;
        pend_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        n_ofire++;
      end

      if (core_valid_in && core_in_ready) begin
        rc_pt  = dec128(core_sh_plaintext);
        rc_key = dec256(core_sh_key);
        chk("in_q_nonempty", in_q.size() > 0, 1);
        if (in_q.size() > 0) begin
          it = in_q.pop_front();
          chk("core_pt", rc_pt, it.pt);
          chk("core_key", it.m256 ? rc_key : {128'h0, rc_key[127:0]},
              it.m256 ? it.key : {128'h0, it.key[127:0]});
          chk("core_mode", {core_inverse, core_mode_256}, {it.inv, it.m256});
        end
        oi.enc = enc128(core_fn(rc_pt, rc_key, core_inverse, core_mode_256));
        oi.rdy = cyc + int'($urandom_range(1, 4));
        core_q.push_back(oi);
      end
    end
  end

  // Core-side drive and mismatch-pulse scoreboard, away from the active edge
  always @(negedge clk) begin : p_drv
    int seen_ofire;
    if (n_ofire != seen_ofire) begin
      chk("mismatch_pulse", mismatch_pulse, pend_exp);
      seen_ofire = n_ofire;
    end
    case (rdy_mode)
      0:       core_in_ready = 1'b1;
      1:       core_in_ready = 1'($urandom_range(0, 1));
      default: core_in_ready = 1'b0;
    endcase
    if (!out_stall && core_q.size() > 0 && cyc >= core_q[0].rdy) begin
      core_cipher_valid  = 1'b1;
      core_sh_ciphertext = core_q[0].enc;
    end else if (!out_stall && core_q.size() == 0 && inj_req != inj_done) begin
      core_cipher_valid  = 1'b1;
      core_sh_ciphertext = enc128(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    end else begin
      core_cipher_valid  = 1'b0;
    end
  end

  task automatic send_vec(input logic [127:0] pt, input logic [255:0] key,
                          input logic [127:0] ex, input logic inv, input logic m256);
    int a0;
    a0 = n_acc;
    vec_plaintext = pt;
    vec_key       = key;
    vec_expected  = ex;
    vec_inverse   = inv;
    vec_mode256   = m256;
    vec_valid     = 1'b1;
    for (int t = 0; t < 4000 && n_acc == a0; t++) @(negedge clk);
    vec_valid = 1'b0;
    chk("accept", n_acc - a0, 1);
  endtask

  task automatic wait_done(input int target);
    for (int t = 0; t < 4000 && n_done < 32'(target); t++) @(negedge clk);
    chk("n_done", n_done, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    vec_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] pt;
    logic [255:0] key;
    logic         inv;
    logic         m256;
    int           a0;
    int           o0;

    // Reset state
    #1;
    chk("rst_out_ready_bp", core_out_ready, 0);
    chk("rst_valid_in", core_valid_in, 0);
    chk("rst_vec_ready", vec_ready, 0);
    chk("rst_n_done", n_done, 0);
    chk("rst_n_fail", n_fail, 0);
    chk("rst_fail_seen", fail_seen, 0);
    chk("rst_pulse", mismatch_pulse, 0);
    chk("rst_first_idx", first_fail_idx, 0);
    bp_en = 1'b0;
    #1;
    chk("rst_out_ready_nobp", core_out_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // FIPS-197 AES-128, continuous
    send_vec(FIPS_PT, K128, C128, 1'b0, 1'b0);
    chk("valid_latency_gap0", core_valid_in, 1);
    wait_done(1);
    chk("aes128_n_fail", n_fail, 0);

    // AES-256, then a decryption whose mode change must wait for the FIFO to drain
    out_stall = 1'b1;
    send_vec(FIPS_PT, K256, C256, 1'b0, 1'b1);
    a0 = n_acc;
    vec_plaintext = C128;
    vec_key       = K128;
    vec_expected  = FIPS_PT;
    vec_inverse   = 1'b1;
    vec_mode256   = 1'b0;
    vec_valid     = 1'b1;
    repeat (10) @(negedge clk);
    chk("mode_stall_ready", vec_ready, 0);
    chk("mode_stall_acc", n_acc - a0, 0);
    out_stall = 1'b0;
    for (int t = 0; t < 200 && n_acc == a0; t++) @(negedge clk);
    vec_valid = 1'b0;
    chk("mode_switch_acc", n_acc - a0, 1);
    wait_done(3);
    chk("mode_n_fail", n_fail, 0);

    // Wrong expected value
    do_reset();
    send_vec(FIPS_PT, K128, {C128[127:8], 8'h5b}, 1'b0, 1'b0);
    wait_done(1);
    chk("bad_pulse", mismatch_pulse, 1);
    chk("bad_n_fail", n_fail, 1);
    chk("bad_fail_seen", fail_seen, 1);
    chk("bad_first_idx", first_fail_idx, 0);
    @(negedge clk);
    chk("bad_pulse_width", mismatch_pulse, 0);

    // FIFO fill under output stall, resume the cycle after a pop
    do_reset();
    out_stall = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      pt  = rand128();
      key = {rand128(), rand128()};
      send_vec(pt, key, core_fn(pt, key, 1'b0, 1'b0), 1'b0, 1'b0);
    end
    a0 = n_acc;
    pt  = rand128();
    key = {rand128(), rand128()};
    vec_plaintext = pt;
    vec_key       = key;
    vec_expected  = core_fn(pt, key, 1'b0, 1'b0);
    vec_inverse   = 1'b0;
    vec_mode256   = 1'b0;
    vec_valid     = 1'b1;
    repeat (8) @(negedge clk);
    chk("full_ready", vec_ready, 0);
    chk("full_acc", n_acc - a0, 0);
    o0 = n_ofire;
    out_stall = 1'b0;
    for (int t = 0; t < 100 && n_ofire == o0; t++) @(negedge clk);
    chk("ready_after_pop", vec_ready, 1);
    for (int t = 0; t < 100 && n_acc == a0; t++) @(negedge clk);
    vec_valid = 1'b0;
    chk("full_resume_acc", n_acc - a0, 1);
    wait_done(DEPTH + 1);
    chk("full_n_fail", n_fail, 0);

    // Random soak: gaps, back-pressure, random input-ready and modes
    do_reset();
    gap_mask = 8'h3F;
    bp_en    = 1'b1;
    rdy_mode = 1;
    for (int k = 0; k < 1000; k++) begin
      pt   = rand128();
      key  = {rand128(), rand128()};
      inv  = 1'($urandom_range(0, 1));
      m256 = 1'($urandom_range(0, 1));
      send_vec(pt, key, core_fn(pt, key, inv, m256), inv, m256);
    end
    wait_done(1000);
    chk("soak_n_fail", n_fail, 0);
    chk("core_in_stable", n_unstable, 0);

    // Reset while driving the core, then a stray result
    gap_mask = 8'h00;
    bp_en    = 1'b0;
    rdy_mode = 2;
    send_vec(FIPS_PT, K128, C128, 1'b0, 1'b0);
    @(negedge clk);
    chk("drive_valid", core_valid_in, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", core_valid_in, 0);
    chk("async_rst_n_done", n_done, 0);
    chk("async_rst_fail_seen", fail_seen, 0);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    rdy_mode = 0;
    inj_req++;
    wait_done(1);
    chk("stray_n_fail", n_fail, 1);
    chk("stray_fail_seen", fail_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
